// File: rtl/shifter_pkg.sv
// Shared encodings for the pipelined barrel shifter: mode/direction codes and
// the per-stage control bundle carried down the pipe.
package shifter_pkg;

  localparam logic [1:0] MODE_LOGICAL = 2'd0;
  localparam logic [1:0] MODE_ARITH   = 2'd1;
  localparam logic [1:0] MODE_ROTATE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
  } shift_ctl_t;

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One combinational barrel-shifter rank: shifts by the constant DIST when en_i
// is set, otherwise passes data through untouched.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shl, shr, sar, rol, ror;

  always_comb begin
    shl = data_i << DIST;
    shr = data_i >> DIST;
    sar = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
    rol = (data_i << DIST) | (data_i >> (WIDTH - DIST));
    ror = (data_i >> DIST) | (data_i << (WIDTH - DIST));
    data_o = data_i;
    if (en_i) begin
      // Arithmetic left and the reserved mode both fall through to logical.
      if (mode_i == MODE_ROTATE)
        data_o = (dir_i == DIR_RIGHT) ? ror : rol;
      else if (mode_i == MODE_ARITH && dir_i == DIR_RIGHT)
        data_o = sar;
      else
        data_o = (dir_i == DIR_RIGHT) ? shr : shl;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register rank per shamt bit, valid/ready on both
// sides, whole pipe stalls together when the output is held.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_dir,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  logic               advance;
  logic               vld_pipe [SHAMT_W+1];
  logic [WIDTH-1:0]   st_data  [SHAMT_W+1];
  logic [SHAMT_W-1:0] st_shamt [SHAMT_W];
  shift_ctl_t         st_ctl   [SHAMT_W];

  assign advance     = !vld_pipe[SHAMT_W] || out_ready;
  assign in_ready    = advance;
  assign vld_pipe[0] = in_valid;
  assign st_data[0]  = in_data;
  assign st_shamt[0] = in_shamt;
  assign st_ctl[0]   = '{dir: in_dir, mode: in_mode};
  assign out_valid   = vld_pipe[SHAMT_W];
  assign out_data    = st_data[SHAMT_W];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_st
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
      .en_i   (st_shamt[k][0]),
      .dir_i  (st_ctl[k].dir),
      .mode_i (st_ctl[k].mode),
      .data_i (st_data[k]),
      .data_o (shifted)
    );

    // Data only loads with a valid entry so out_data stays 0 until the first result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (advance) begin
        vld_q <= vld_pipe[k];
        if (vld_pipe[k]) data_q <= shifted;
      end
    end

    assign vld_pipe[k+1] = vld_q;
    assign st_data[k+1]  = data_q;

    // The last rank needs no control forward; remaining shamt bits shift down.
    if (k < SHAMT_W - 1) begin : g_ctl
      logic [SHAMT_W-1:0] shamt_q;
      shift_ctl_t         ctl_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shamt_q <= '0;
          ctl_q   <= '0;
        end else if (advance && vld_pipe[k]) begin
          shamt_q <= st_shamt[k] >> 1;
          ctl_q   <= st_ctl[k];
        end
      end

      assign st_shamt[k+1] = shamt_q;
      assign st_ctl[k+1]   = ctl_q;
    end
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's 8-bit bidirectional barrel shifter.
- Adds configurable WIDTH, logical, arithmetic and rotate modes, and a per-bit-of-shamt register stage.
- Adds valid/ready handshakes on both sides, so it can sit in the datapath between an operand source and a result consumer at full throughput with backpressure.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two and at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; also the pipeline depth in stages.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present on in_data/in_shamt/in_dir/in_mode.
- in_ready  output  1  shifter can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_dir  input  1  0 = left, 1 = right.
- in_mode  input  2  0 = logical, 1 = arithmetic, 2 = rotate, 3 = reserved (treated as logical).
- out_valid  output  1  result present on out_data.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Reset (async assert, sync deassert by design convention): all stage valid bits, out_valid and out_data go to 0. in_ready reads 1 once rst_n is high.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline:
  - SHAMT_W register stages. Stage k applies a shift of 2^k when bit k of the carried shamt is 1, otherwise it passes data through.
  - Each stage carries data, the remaining shamt bits, dir, mode and a valid bit.
- Latency: the result appears on out_valid/out_data exactly SHAMT_W cycles after the input transfer cycle when not stalled (3 cycles at WIDTH=8).
- Throughput: one operand per cycle.
- Stall rule:
  - advance = !out_valid || out_ready. All stages load only when advance = 1, otherwise every stage holds.
  - in_ready = advance (combinational from out_ready and out_valid).
  - Holds are loss-free and order-preserving.
  - Bubble stages (valid = 0) still advance under the same rule; there is no bubble collapse.
- out_data and out_valid must stay stable while out_valid && !out_ready.
- Mode rules per stage, for a shift by s:
  - Logical left: shift in zeros at the LSB.
  - Logical right: shift in zeros at the MSB.
  - Arithmetic right: replicate the operand MSB (the MSB of the stage input).
  - Arithmetic left: identical to logical left.
  - Rotate: bits leaving one end enter the other end.
  - Mode 3: identical to logical.
- in_shamt = 0 gives out_data = in_data in every mode, with the same latency.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full rate.
- Reset mid-operation: all in-flight operands are discarded, nothing emerges after deassertion, and the first post-reset input gets normal latency.
- in_data/in_shamt/in_dir/in_mode are don't-care when in_valid = 0. A stage holding an invalid entry may hold arbitrary data, but out_data is required to be 0 only after reset until the first valid result.

Decomposition:
- Package shifter_pkg:
  - Mode constants: MODE_LOGICAL = 2'd0, MODE_ARITH = 2'd1, MODE_ROTATE = 2'd2.
  - Direction constants: DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
- Sub-module shift_stage:
  - Combinational single-stage shift by a constant parameter DIST (2^k), selected by an enable bit, dir and mode.
  - Instantiated SHAMT_W times via generate; the top level owns the registers and the handshake logic.

Test Plan:
- Basic directions, WIDTH=8, mode 0, out_ready = 1:
  - in_data = 0x31, shamt = 3, dir = 0 -> out_data = 0x88 on the 3rd cycle after transfer.
  - Same with dir = 1 -> 0x06.
- Rotate, in_data = 0x31, shamt = 3:
  - dir = 0 -> 0x89.
  - dir = 1 -> 0x26.
- Arithmetic:
  - in_data = 0xB5, shamt = 2, dir = 1, mode 1 -> 0xED.
  - Same with mode 0 -> 0x2D.
  - Same with dir = 0, mode 1 -> 0xD4.
- Back-to-back throughput: 8 consecutive operands 0x01..0x08, shamt = 1, dir = 0, mode 0, out_ready = 1 -> 0x02,0x04,..,0x10 on 8 consecutive cycles, with in_ready held at 1.
- Backpressure: stream as in the previous scenario with out_ready = 0 for 5 cycles mid-stream -> in_ready = 0 during the stall, out_data held stable, no loss or reorder, full sequence delivered.
- Reset and boundaries:
  - Assert rst_n = 0 with 2 operands in flight -> out_valid = 0 immediately; after release nothing emerges.
  - Then shamt = 0, in_data = 0xA5 -> out_data = 0xA5.
  - Then shamt = 7, dir = 1, mode 1, in_data = 0x80 -> 0xFF.
